// File: rtl/phy_slot_sched.sv
// phy_slot_sched: sequences one phy_channel acquisition cycle.
// Emits a frame sync, waits GAP_CYC idle cycles, then runs one slot per
// enabled virtual channel (lowest index first) and finishes with a
// one-cycle completion pulse. The configuration is captured once per
// cycle, so host register writes mid-cycle do not disturb the running cycle.
module phy_slot_sched #(
    parameter int SLOT_W  = 16,
    parameter int GAP_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [3:0]        i_vchn_en,
    input  logic [31:0]       i_len_all,
    input  logic [SLOT_W-1:0] i_slot_period,
    output logic              o_sync,
    output logic              o_slot_sync,
    output logic [1:0]        o_wr_vchn,
    output logic [7:0]        o_data_len,
    output logic [3:0]        o_ch_mask,
    output logic              o_complite,
    output logic              o_busy,
    output logic              o_overrun
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SYNC       = 3'd1,
        ST_GAP        = 3'd2,
        ST_SLOT_START = 3'd3,
        ST_SLOT_RUN   = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    state_t            state_r;
    logic [3:0]        en_sh_r;
    logic [31:0]       len_sh_r;
    logic [SLOT_W-1:0] per_m1_sh_r;   // slot length minus one, period 0 folded to 1
    logic [GAP_W-1:0]  gap_cnt_r;
    logic [SLOT_W-1:0] slot_cnt_r;

    logic              sync_r;
    logic              slot_sync_r;
    logic [1:0]        wr_vchn_r;
    logic [7:0]        data_len_r;
    logic [3:0]        ch_mask_r;
    logic              complite_r;
    logic              busy_r;
    logic              overrun_r;

    logic [2:0]        from_s;
    logic [2:0]        nxt_s;
    logic              nxt_found_s;
    logic [1:0]        nxt_idx_s;
    logic              slot_last_s;

    // Lowest enabled vchn with index >= from; returns {found, index}.
    function automatic logic [2:0] find_next(input logic [3:0] en, input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (en[i] && (3'(i) >= from)) begin
                res = {1'b1, 2'(i)};
            end
        end
        return res;
    endfunction

    // Byte lane of the packed length word for one vchn.
    function automatic logic [7:0] len_sel(input logic [31:0] len_all, input logic [1:0] idx);
        logic [7:0] res;
        case (idx)
            2'd0:    res = len_all[7:0];
            2'd1:    res = len_all[15:8];
            2'd2:    res = len_all[23:16];
            2'd3:    res = len_all[31:24];
            default: res = 8'd0;
        endcase
        return res;
    endfunction

    // Channel mask bit for one vchn.
    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Search start point and terminal slot-count compare for the next decision.
    always_comb begin
        from_s = 3'd0;
        if (state_r == ST_GAP) begin
            from_s = 3'd0;
        end else begin
            from_s = {1'b0, wr_vchn_r} + 3'd1;
        end
        nxt_s       = find_next(en_sh_r, from_s);
        nxt_found_s = nxt_s[2];
        nxt_idx_s   = nxt_s[1:0];
        slot_last_s = (slot_cnt_r == per_m1_sh_r);
    end

    // Cycle sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            en_sh_r     <= 4'd0;
            len_sh_r    <= 32'd0;
            per_m1_sh_r <= {SLOT_W{1'b0}};
            gap_cnt_r   <= {GAP_W{1'b0}};
            slot_cnt_r  <= {SLOT_W{1'b0}};
            sync_r      <= 1'b0;
            slot_sync_r <= 1'b0;
            wr_vchn_r   <= 2'd0;
            data_len_r  <= 8'd0;
            ch_mask_r   <= 4'd0;
            complite_r  <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            overrun_r   <= i_start && (state_r != ST_IDLE);
            sync_r      <= 1'b0;
            slot_sync_r <= 1'b0;
            complite_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        state_r <= ST_SYNC;
                        sync_r  <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SYNC: begin
                    en_sh_r  <= i_vchn_en;
                    len_sh_r <= i_len_all;
                    if (i_slot_period == {SLOT_W{1'b0}}) begin
                        per_m1_sh_r <= {SLOT_W{1'b0}};
                    end else begin
                        per_m1_sh_r <= i_slot_period - SLOT_W'(1);
                    end
                    gap_cnt_r <= {GAP_W{1'b0}};
                    state_r   <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_W'(GAP_CYC - 1)) begin
                        if (nxt_found_s) begin
                            state_r     <= ST_SLOT_START;
                            slot_sync_r <= 1'b1;
                            wr_vchn_r   <= nxt_idx_s;
                            data_len_r  <= len_sel(len_sh_r, nxt_idx_s);
                            ch_mask_r   <= onehot(nxt_idx_s);
                            slot_cnt_r  <= {SLOT_W{1'b0}};
                        end else begin
                            state_r    <= ST_DONE;
                            complite_r <= 1'b1;
                        end
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                ST_SLOT_START, ST_SLOT_RUN: begin
                    if (slot_last_s) begin
                        if (nxt_found_s) begin
                            state_r     <= ST_SLOT_START;
                            slot_sync_r <= 1'b1;
                            wr_vchn_r   <= nxt_idx_s;
                            data_len_r  <= len_sel(len_sh_r, nxt_idx_s);
                            ch_mask_r   <= onehot(nxt_idx_s);
                            slot_cnt_r  <= {SLOT_W{1'b0}};
                        end else begin
                            state_r    <= ST_DONE;
                            complite_r <= 1'b1;
                            ch_mask_r  <= 4'd0;
                        end
                    end else begin
                        state_r    <= ST_SLOT_RUN;
                        slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    ch_mask_r <= 4'd0;
                end
            endcase
        end
    end

    assign o_sync      = sync_r;
    assign o_slot_sync = slot_sync_r;
    assign o_wr_vchn   = wr_vchn_r;
    assign o_data_len  = data_len_r;
    assign o_ch_mask   = ch_mask_r;
    assign o_complite  = complite_r;
    assign o_busy      = busy_r;
    assign o_overrun   = overrun_r;

endmodule

// File: tb/tb_phy_slot_sched.sv
// Scoreboard bench for phy_slot_sched: stimulus pushes hand-computed
// expected pulses (cycle, kind, vchn, len, mask) into queues; a monitor
// pops and compares whenever the DUT raises sync/slot_sync/complite/overrun.
module tb_phy_slot_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [3:0]  i_vchn_en;
    logic [31:0] i_len_all;
    logic [15:0] i_slot_period;
    logic        o_sync;
    logic        o_slot_sync;
    logic [1:0]  o_wr_vchn;
    logic [7:0]  o_data_len;
    logic [3:0]  o_ch_mask;
    logic        o_complite;
    logic        o_busy;
    logic        o_overrun;

    phy_slot_sched #(.SLOT_W(16), .GAP_CYC(2)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_vchn_en(i_vchn_en),
        .i_len_all(i_len_all), .i_slot_period(i_slot_period),
        .o_sync(o_sync), .o_slot_sync(o_slot_sync), .o_wr_vchn(o_wr_vchn),
        .o_data_len(o_data_len), .o_ch_mask(o_ch_mask), .o_complite(o_complite),
        .o_busy(o_busy), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         kind;   // 0 sync, 1 slot_sync, 2 complite
        logic [1:0] vchn;
        logic [7:0] len;
        logic [3:0] mask;
    } evt_t;

    evt_t       q_evt[$];
    int         q_ovr[$];
    int         n_vec  = 0;
    int         n_fail = 0;
    logic [3:0] cur_mask = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_evt(input int c, input int k, input logic [1:0] v,
                            input logic [7:0] l, input logic [3:0] m);
        evt_t e;
        e.cyc = c; e.kind = k; e.vchn = v; e.len = l; e.mask = m;
        q_evt.push_back(e);
    endtask

    task automatic take_evt(input int k);
        evt_t e;
        if (q_evt.size() == 0) begin
            chk("unexpected_pulse_kind", 32'(k), 32'hFFFF_FFFF);
        end else begin
            e = q_evt.pop_front();
            chk("evt_kind", 32'(k), 32'(e.kind));
            chk("evt_cyc", 32'(cyc), 32'(e.cyc));
            chk("evt_busy", 32'(o_busy), 32'd1);
            if (k != 0) begin
                chk("evt_vchn", 32'(o_wr_vchn), 32'(e.vchn));
                chk("evt_len", 32'(o_data_len), 32'(e.len));
            end else begin
                n_vec = n_vec;
            end
            if (k == 1) begin
                cur_mask = e.mask;
            end else begin
                cur_mask = 4'd0;
            end
        end
    endtask

    // Monitor: compare every presented pulse against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            cur_mask = 4'd0;
        end else begin
            chk("pulse_exclusive", 32'($countones({o_sync, o_slot_sync, o_complite}) <= 1), 32'd1);
            if (o_sync)      take_evt(0);
            if (o_slot_sync) take_evt(1);
            if (o_complite)  take_evt(2);
            if (o_overrun) begin
                if (q_ovr.size() == 0) begin
                    chk("unexpected_overrun", 32'd1, 32'd0);
                end else begin
                    chk("overrun_cyc", 32'(cyc), 32'(q_ovr.pop_front()));
                end
            end
            chk("ch_mask", 32'(o_ch_mask), 32'(cur_mask));
        end
    end

    task automatic do_start(output int t0);
        t0 = cyc;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        for (int i = 0; (i < 2000) && (cyc < c); i++) @(negedge clk);
        chk("wait_bound", 32'(cyc >= c), 32'd1);
    endtask

    task automatic cfg(input logic [3:0] en, input logic [31:0] len, input logic [15:0] p);
        i_vchn_en = en; i_len_all = len; i_slot_period = p;
    endtask

    // Full 4-slot cycle with P=8 and lengths 10..40.
    task automatic push_test1(input int t0);
        push_evt(t0 + 1,  0, 2'd0, 8'd0,  4'b0000);
        push_evt(t0 + 4,  1, 2'd0, 8'd10, 4'b0001);
        push_evt(t0 + 12, 1, 2'd1, 8'd20, 4'b0010);
        push_evt(t0 + 20, 1, 2'd2, 8'd30, 4'b0100);
        push_evt(t0 + 28, 1, 2'd3, 8'd40, 4'b1000);
        push_evt(t0 + 36, 2, 2'd3, 8'd40, 4'b0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst = 1'b1; i_start = 1'b0;
        cfg(4'd0, 32'd0, 16'd0);
        repeat (3) @(negedge clk);
        chk("rst_sync", 32'(o_sync), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_mask", 32'(o_ch_mask), 32'd0);
        chk("rst_len", 32'(o_data_len), 32'd0);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1
        cfg(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, 16'd8);
        do_start(t0);
        push_test1(t0);
        wait_until(t0 + 36);
        chk("busy_at_complite", 32'(o_busy), 32'd1);
        wait_until(t0 + 37);
        chk("busy_after_done", 32'(o_busy), 32'd0);
        chk("vchn_hold", 32'(o_wr_vchn), 32'd3);

        // Test 2: only vchn 0 and 2, P=5
        cfg(4'b0101, {8'd44, 8'd33, 8'd22, 8'd11}, 16'd5);
        do_start(t0);
        push_evt(t0 + 1,  0, 2'd0, 8'd0,  4'b0000);
        push_evt(t0 + 4,  1, 2'd0, 8'd11, 4'b0001);
        push_evt(t0 + 9,  1, 2'd2, 8'd33, 4'b0100);
        push_evt(t0 + 14, 2, 2'd2, 8'd33, 4'b0000);
        wait_until(t0 + 16);

        // Test 3: nothing enabled; start in DONE overruns, start next cycle accepted
        cfg(4'b0000, 32'h0403_0201, 16'd5);
        do_start(t0);
        push_evt(t0 + 1, 0, 2'd0, 8'd0,  4'b0000);
        push_evt(t0 + 4, 2, 2'd2, 8'd33, 4'b0000);
        wait_until(t0 + 4);
        i_start = 1'b1;
        q_ovr.push_back(t0 + 5);
        @(negedge clk);
        i_start = 1'b1;
        push_evt(t0 + 6, 0, 2'd0, 8'd0,  4'b0000);
        push_evt(t0 + 9, 2, 2'd2, 8'd33, 4'b0000);
        @(negedge clk);
        i_start = 1'b0;
        wait_until(t0 + 11);

        // Test 4: period 0 and 1 behave as single-cycle slots
        for (int p = 0; p < 2; p++) begin
            cfg(4'b0011, 32'h0403_0201, 16'(p));
            do_start(t0);
            push_evt(t0 + 1, 0, 2'd0, 8'd0, 4'b0000);
            push_evt(t0 + 4, 1, 2'd0, 8'd1, 4'b0001);
            push_evt(t0 + 5, 1, 2'd1, 8'd2, 4'b0010);
            push_evt(t0 + 6, 2, 2'd1, 8'd2, 4'b0000);
            wait_until(t0 + 8);
        end

        // Test 5: start and config change mid-cycle
        cfg(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, 16'd8);
        do_start(t0);
        push_test1(t0);
        wait_until(t0 + 10);
        cfg(4'b0001, 32'hFFFF_FFFF, 16'd2);
        i_start = 1'b1;
        q_ovr.push_back(t0 + 11);
        @(negedge clk);
        i_start = 1'b0;
        wait_until(t0 + 38);

        // Test 6: async reset mid-cycle aborts, then a full cycle runs
        cfg(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, 16'd8);
        do_start(t0);
        push_evt(t0 + 1,  0, 2'd0, 8'd0,  4'b0000);
        push_evt(t0 + 4,  1, 2'd0, 8'd10, 4'b0001);
        push_evt(t0 + 12, 1, 2'd1, 8'd20, 4'b0010);
        wait_until(t0 + 15);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_mask", 32'(o_ch_mask), 32'd0);
        chk("arst_vchn", 32'(o_wr_vchn), 32'd0);
        chk("arst_len", 32'(o_data_len), 32'd0);
        chk("arst_pulses", 32'({o_sync, o_slot_sync, o_complite, o_overrun}), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (30) @(negedge clk);
        do_start(t0);
        push_test1(t0);
        wait_until(t0 + 40);

        chk("evt_queue_drained", 32'(q_evt.size()), 32'd0);
        chk("ovr_queue_drained", 32'(q_ovr.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
